// File: rtl/odometer_seq_stacked_if.sv
// Control/status bundle between the configuration registers and the odometer sequencer.
// The sequencer connects through the slave modport; its driver uses the master modport.
interface odometer_seq_stacked_if #(
  parameter int CNT_W    = 16,
  parameter int STRESS_W = 24,
  parameter int GATE_W   = 12,
  parameter int AC_DIV_W = 4
);
  logic                CMD_START;
  logic                CMD_ABORT;
  logic                MEAS_ONLY;
  logic                AC_MODE;
  logic [AC_DIV_W-1:0] AC_DIV;
  logic [STRESS_W-1:0] STRESS_CYCLES;
  logic [GATE_W-1:0]   GATE_CYCLES;
  logic                ROSC_OUT;

  logic                SEL_INV99;
  logic                SEL_INV101;
  logic                SEL_INV97;
  logic                START;
  logic                AC_DC;
  logic                AC_STRESS_CLK;
  logic                EN_POWER_ROSC;
  logic                EN_ROSC;
  logic                MEAS_STRESS;
  logic [CNT_W-1:0]    COUNT;
  logic [1:0]          COUNT_ID;
  logic                COUNT_VALID;
  logic                COUNT_SAT;
  logic                BUSY;
  logic                DONE;

  modport master (
    output CMD_START, CMD_ABORT, MEAS_ONLY, AC_MODE, AC_DIV, STRESS_CYCLES,
           GATE_CYCLES, ROSC_OUT,
    input  SEL_INV99, SEL_INV101, SEL_INV97, START, AC_DC, AC_STRESS_CLK,
           EN_POWER_ROSC, EN_ROSC, MEAS_STRESS, COUNT, COUNT_ID, COUNT_VALID,
           COUNT_SAT, BUSY, DONE
  );

  modport slave (
    input  CMD_START, CMD_ABORT, MEAS_ONLY, AC_MODE, AC_DIV, STRESS_CYCLES,
           GATE_CYCLES, ROSC_OUT,
    output SEL_INV99, SEL_INV101, SEL_INV97, START, AC_DC, AC_STRESS_CLK,
           EN_POWER_ROSC, EN_ROSC, MEAS_STRESS, COUNT, COUNT_ID, COUNT_VALID,
           COUNT_SAT, BUSY, DONE
  );
endinterface

// File: rtl/odometer_seq_stacked.sv
// Stress/measure sequencer for the stacked INV99/INV101/INV97 ring-oscillator odometer.
// Stresses all rings, then settles and gate-counts each ring in turn; every output is registered.
module odometer_seq_stacked #(
  parameter int CNT_W         = 16,
  parameter int STRESS_W      = 24,
  parameter int GATE_W        = 12,
  parameter int SETTLE_CYCLES = 8,
  parameter int AC_DIV_W      = 4
) (
  input logic                  CLK,
  input logic                  RST,
  odometer_seq_stacked_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_STRESS,
    S_SETTLE,
    S_MEAS,
    S_FINISH
  } state_t;

  typedef struct packed {
    logic [2:0] sel;      // bit0 INV99, bit1 INV101, bit2 INV97
    logic       start;
    logic       ac_dc;
    logic       en_pwr;
    logic       en_rosc;
  } ctl_t;

  localparam int SET_W = $clog2(SETTLE_CYCLES) + 1;
  localparam int TMR_A = (STRESS_W > GATE_W) ? STRESS_W : GATE_W;
  localparam int TMR_W = (TMR_A > SET_W) ? TMR_A : SET_W;

  function automatic ctl_t ctl_settle(input logic [1:0] idx);
    ctl_t c;
    c         = '0;
    c.sel     = 3'b001 << idx;
    c.en_pwr  = 1'b1;
    c.en_rosc = 1'b1;
    return c;
  endfunction

  function automatic ctl_t ctl_stress(input logic ac);
    ctl_t c;
    c        = '0;
    c.start  = 1'b1;
    c.ac_dc  = ac;
    c.en_pwr = 1'b1;
    return c;
  endfunction

  state_t              r_state;
  ctl_t                r_ctl;
  logic                r_ac_clk;
  logic [1:0]          r_idx;
  logic [TMR_W-1:0]    r_timer;
  logic [AC_DIV_W-1:0] r_div_cnt;
  logic                r_ac_mode;
  logic [AC_DIV_W-1:0] r_ac_div;
  logic [GATE_W-1:0]   r_gate_m1;
  logic                r_s1, r_s2, r_s3;
  logic [CNT_W-1:0]    r_edge_cnt;
  logic                r_sat;
  logic [CNT_W-1:0]    r_count;
  logic [1:0]          r_count_id;
  logic                r_count_valid;
  logic                r_count_sat;
  logic                r_busy;
  logic                r_done;

  logic                w_edge;
  logic [CNT_W-1:0]    w_cnt_next;
  logic                w_sat_next;
  logic [GATE_W-1:0]   w_gate_m1;
  logic                w_skip_stress;

  assign w_edge        = r_s2 & ~r_s3;
  assign w_gate_m1     = (bus.GATE_CYCLES == '0) ? '0 : bus.GATE_CYCLES - GATE_W'(1);
  assign w_skip_stress = bus.MEAS_ONLY || (bus.STRESS_CYCLES == '0);

  // NOTE: every variable written in always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    w_cnt_next = r_edge_cnt;
    w_sat_next = r_sat;
    if (w_edge) begin
      if (&r_edge_cnt) w_sat_next = 1'b1;
      else             w_cnt_next = r_edge_cnt + CNT_W'(1);
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state       <= S_IDLE;
      r_ctl         <= '0;
      r_ac_clk      <= 1'b0;
      r_idx         <= '0;
      r_timer       <= '0;
      r_div_cnt     <= '0;
      r_ac_mode     <= 1'b0;
      r_ac_div      <= '0;
      r_gate_m1     <= '0;
      r_s1          <= 1'b0;
      r_s2          <= 1'b0;
      r_s3          <= 1'b0;
      r_edge_cnt    <= '0;
      r_sat         <= 1'b0;
      r_count       <= '0;
      r_count_id    <= '0;
      r_count_valid <= 1'b0;
      r_count_sat   <= 1'b0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
    end else begin
      r_s1          <= bus.ROSC_OUT;
      r_s2          <= r_s1;
      r_s3          <= r_s2;
      r_count_valid <= 1'b0;
      r_done        <= 1'b0;

      if (r_state != S_IDLE && bus.CMD_ABORT) begin
        // Abort drops the rings immediately and leaves the last reported count untouched.
        r_state  <= S_IDLE;
        r_ctl    <= '0;
        r_ac_clk <= 1'b0;
        r_busy   <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (bus.CMD_START && !bus.CMD_ABORT) begin
              r_ac_mode <= bus.AC_MODE;
              r_ac_div  <= bus.AC_DIV;
              r_gate_m1 <= w_gate_m1;
              r_busy    <= 1'b1;
              r_ac_clk  <= 1'b0;
              r_div_cnt <= '0;
              if (w_skip_stress) begin
                r_state <= S_SETTLE;
                r_idx   <= 2'd0;
                r_timer <= TMR_W'(SETTLE_CYCLES - 1);
                r_ctl   <= ctl_settle(2'd0);
              end else begin
                r_state <= S_STRESS;
                r_timer <= TMR_W'(bus.STRESS_CYCLES) - TMR_W'(1);
                r_ctl   <= ctl_stress(bus.AC_MODE);
              end
            end
          end

          S_STRESS: begin
            if (r_timer == '0) begin
              r_state  <= S_SETTLE;
              r_idx    <= 2'd0;
              r_timer  <= TMR_W'(SETTLE_CYCLES - 1);
              r_ctl    <= ctl_settle(2'd0);
              r_ac_clk <= 1'b0;
            end else begin
              r_timer <= r_timer - TMR_W'(1);
              if (r_ac_mode) begin
                if (r_div_cnt == r_ac_div) begin
                  r_div_cnt <= '0;
                  r_ac_clk  <= ~r_ac_clk;
                end else begin
                  r_div_cnt <= r_div_cnt + AC_DIV_W'(1);
                end
              end
            end
          end

          S_SETTLE: begin
            if (r_timer == '0) begin
              r_state    <= S_MEAS;
              r_timer    <= TMR_W'(r_gate_m1);
              r_edge_cnt <= '0;
              r_sat      <= 1'b0;
            end else begin
              r_timer <= r_timer - TMR_W'(1);
            end
          end

          S_MEAS: begin
            r_edge_cnt <= w_cnt_next;
            r_sat      <= w_sat_next;
            if (r_timer == '0) begin
              r_count_valid <= 1'b1;
              r_count       <= w_cnt_next;
              r_count_sat   <= w_sat_next;
              r_count_id    <= r_idx;
              if (r_idx == 2'd2) begin
                r_state <= S_FINISH;
                r_ctl   <= '0;
                r_done  <= 1'b1;
              end else begin
                r_state <= S_SETTLE;
                r_idx   <= r_idx + 2'd1;
                r_timer <= TMR_W'(SETTLE_CYCLES - 1);
                r_ctl   <= ctl_settle(r_idx + 2'd1);
              end
            end else begin
              r_timer <= r_timer - TMR_W'(1);
            end
          end

          S_FINISH: begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end

          default: begin
            r_state <= S_IDLE;
            r_ctl   <= '0;
            r_busy  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.SEL_INV99     = r_ctl.sel[0];
  assign bus.SEL_INV101    = r_ctl.sel[1];
  assign bus.SEL_INV97     = r_ctl.sel[2];
  assign bus.START         = r_ctl.start;
  assign bus.AC_DC         = r_ctl.ac_dc;
  assign bus.AC_STRESS_CLK = r_ac_clk;
  assign bus.EN_POWER_ROSC = r_ctl.en_pwr;
  assign bus.EN_ROSC       = r_ctl.en_rosc;
  assign bus.MEAS_STRESS   = 1'b0;
  assign bus.COUNT         = r_count;
  assign bus.COUNT_ID      = r_count_id;
  assign bus.COUNT_VALID   = r_count_valid;
  assign bus.COUNT_SAT     = r_count_sat;
  assign bus.BUSY          = r_busy;
  assign bus.DONE          = r_done;

endmodule

// File: tb/tb_odometer_seq_stacked.sv
// Self-checking bench for odometer_seq_stacked: table-driven runs with a count scoreboard,
// plus hand sequences for abort, ignored starts and counter saturation.
module tb_odometer_seq_stacked;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  always #5 CLK = ~CLK;

  odometer_seq_stacked_if bus ();
  odometer_seq_stacked_if #(.CNT_W(4)) bus2 ();

  odometer_seq_stacked dut (.CLK(CLK), .RST(RST), .bus(bus));
  odometer_seq_stacked #(.CNT_W(4)) dut_sat (.CLK(CLK), .RST(RST), .bus(bus2));

  typedef struct {
    logic [1:0] id;
    int         lo;
    int         hi;
  } exp_t;

  typedef struct {
    bit meas_only;
    bit ac_mode;
    int ac_div;
    int stress;
    int gate;
    int half;
    int exp_stress;
    int exp_rises;
    int exp_first_rise;
    int exp_high;
    int exp_first_sel;
    int exp_total;
    int exp_lo;
    int exp_hi;
  } vec_t;

  exp_t sb[$];
  vec_t vecs[5];

  int total = 0;
  int bad   = 0;

  int rosc_half = 0;
  int rosc_ph   = 0;
  int rosc2_ph  = 0;

  bit run_active = 0;
  int run_cyc, stress_cnt, ac_rises, ac_first, ac_high, first_sel;
  int valid_cnt, done_seen, done_cyc, viol;
  bit prev_ac, exp_ac_dc;

  task automatic check(input string name, input longint act, input longint lo, input longint hi);
    total++;
    if (act < lo || act > hi) begin
      bad++;
      $display("FAIL %s: got %0d want %0d..%0d", name, act, lo, hi);
    end
  endtask

  // Ring oscillator stand-ins, toggled away from the sampling edge.
  always @(negedge CLK) begin
    if (rosc_half != 0) begin
      if (rosc_ph >= rosc_half - 1) begin
        bus.ROSC_OUT = ~bus.ROSC_OUT;
        rosc_ph      = 0;
      end else rosc_ph++;
    end else bus.ROSC_OUT = 1'b0;
    if (rosc2_ph >= 1) begin
      bus2.ROSC_OUT = ~bus2.ROSC_OUT;
      rosc2_ph      = 0;
    end else rosc2_ph++;
  end

  // Output monitor and scoreboard consumer.
  always @(negedge CLK) begin
    if (run_active) begin
      run_cyc++;
      if (bus.START) begin
        stress_cnt++;
        if (bus.AC_DC !== exp_ac_dc || !bus.EN_POWER_ROSC || bus.EN_ROSC) viol++;
      end
      if (bus.AC_STRESS_CLK) begin
        ac_high++;
        if (!bus.START) viol++;
        if (!prev_ac) begin
          ac_rises++;
          if (ac_first == 0) ac_first = run_cyc;
        end
      end
      prev_ac = bus.AC_STRESS_CLK;
      if (bus.SEL_INV99 && first_sel == 0) first_sel = run_cyc;
      if ($countones({bus.SEL_INV99, bus.SEL_INV101, bus.SEL_INV97}) > 1 || bus.MEAS_STRESS) viol++;
      if ((bus.SEL_INV99 || bus.SEL_INV101 || bus.SEL_INV97) && (!bus.EN_ROSC || !bus.EN_POWER_ROSC)) viol++;
      if (bus.DONE) begin
        done_seen++;
        done_cyc = run_cyc;
        if (bus.EN_POWER_ROSC || bus.EN_ROSC || bus.START) viol++;
      end
    end
    if (bus.COUNT_VALID) begin
      valid_cnt++;
      if (sb.size() == 0) begin
        check("unexpected_count_valid", 1, 0, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("count_id", bus.COUNT_ID, e.id, e.id);
        check("count_value", bus.COUNT, e.lo, e.hi);
        check("count_sat", bus.COUNT_SAT, 0, 0);
      end
    end
  end

  task automatic push_exp(input int n, input int lo, input int hi);
    for (int i = 0; i < n; i++) begin
      exp_t e;
      e.id = 2'(i);
      e.lo = lo;
      e.hi = hi;
      sb.push_back(e);
    end
  endtask

  task automatic start_run(input bit mo, input bit am, input int div, input int s, input int g, input int h);
    @(posedge CLK); #1;
    rosc_half  = h;
    exp_ac_dc  = am;
    stress_cnt = 0; ac_rises = 0; ac_first = 0; ac_high = 0; first_sel = 0;
    valid_cnt  = 0; done_seen = 0; done_cyc = 0; viol = 0; prev_ac = 0;
    bus.MEAS_ONLY     = mo;
    bus.AC_MODE       = am;
    bus.AC_DIV        = 4'(div);
    bus.STRESS_CYCLES = 24'(s);
    bus.GATE_CYCLES   = 12'(g);
    bus.CMD_START     = 1'b1;
    @(posedge CLK);
    run_cyc    = 0;
    run_active = 1;
    #1 bus.CMD_START = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    while (done_seen == 0 && n < 5000) begin
      @(posedge CLK);
      n++;
    end
    check("done_seen", done_seen, 1, 1);
    @(negedge CLK);
    check("busy_after_done", bus.BUSY, 0, 0);
  endtask

  task automatic wait_cyc(input int c);
    int n = 0;
    while (run_cyc < c && n < 5000) begin
      @(posedge CLK); #1;
      n++;
    end
  endtask

  initial begin
    int nv;
    int n;

    vecs[0] = '{0, 0, 0, 20, 100, 4, 20, 0, 0, 0, 21, 345, 12, 13};
    vecs[1] = '{0, 1, 2, 30,  40, 4, 30, 5, 4, 15, 31, 175,  5,  5};
    vecs[2] = '{1, 1, 0, 20,  10, 2,  0, 0, 0,  0,  1,  55,  2,  3};
    vecs[3] = '{0, 0, 0,  0,   0, 3,  0, 0, 0,  0,  1,  28,  0,  1};
    vecs[4] = '{0, 1, 0,  5,   1, 0,  5, 2, 2,  2,  6,  33,  0,  0};

    bus.CMD_START = 0; bus.CMD_ABORT = 0; bus.MEAS_ONLY = 0; bus.AC_MODE = 0;
    bus.AC_DIV = 0; bus.STRESS_CYCLES = 0; bus.GATE_CYCLES = 0; bus.ROSC_OUT = 0;
    bus2.CMD_START = 0; bus2.CMD_ABORT = 0; bus2.MEAS_ONLY = 0; bus2.AC_MODE = 0;
    bus2.AC_DIV = 0; bus2.STRESS_CYCLES = 0; bus2.GATE_CYCLES = 0; bus2.ROSC_OUT = 0;

    // Reset state.
    RST = 1'b1;
    repeat (2) @(posedge CLK);
    #1 RST = 1'b0;
    @(negedge CLK);
    check("rst_busy", bus.BUSY, 0, 0);
    check("rst_count", bus.COUNT, 0, 0);
    check("rst_count_id", bus.COUNT_ID, 0, 0);
    check("rst_valid_done_sat", {bus.COUNT_VALID, bus.DONE, bus.COUNT_SAT}, 0, 0);
    check("rst_controls", {bus.SEL_INV99, bus.SEL_INV101, bus.SEL_INV97, bus.START, bus.AC_DC,
                           bus.AC_STRESS_CLK, bus.EN_POWER_ROSC, bus.EN_ROSC, bus.MEAS_STRESS}, 0, 0);

    // Table-driven full runs.
    for (int i = 0; i < 5; i++) begin
      push_exp(3, vecs[i].exp_lo, vecs[i].exp_hi);
      start_run(vecs[i].meas_only, vecs[i].ac_mode, vecs[i].ac_div, vecs[i].stress,
                vecs[i].gate, vecs[i].half);
      wait_done();
      check($sformatf("v%0d_total", i), done_cyc, vecs[i].exp_total, vecs[i].exp_total);
      check($sformatf("v%0d_stress_cycles", i), stress_cnt, vecs[i].exp_stress, vecs[i].exp_stress);
      check($sformatf("v%0d_ac_rises", i), ac_rises, vecs[i].exp_rises, vecs[i].exp_rises);
      check($sformatf("v%0d_ac_high", i), ac_high, vecs[i].exp_high, vecs[i].exp_high);
      if (vecs[i].exp_rises > 0)
        check($sformatf("v%0d_ac_first", i), ac_first, vecs[i].exp_first_rise, vecs[i].exp_first_rise);
      check($sformatf("v%0d_first_sel", i), first_sel, vecs[i].exp_first_sel, vecs[i].exp_first_sel);
      check($sformatf("v%0d_valids", i), valid_cnt, 3, 3);
      check($sformatf("v%0d_violations", i), viol, 0, 0);
      check($sformatf("v%0d_sb_empty", i), sb.size(), 0, 0);
      run_active = 0;
    end

    // CMD_START while busy must not relaunch or relatch.
    push_exp(3, 2, 3);
    start_run(1, 0, 0, 0, 10, 2);
    wait_cyc(12);
    bus.MEAS_ONLY = 0; bus.STRESS_CYCLES = 50; bus.GATE_CYCLES = 200;
    bus.CMD_START = 1'b1;
    @(posedge CLK); #1 bus.CMD_START = 1'b0;
    wait_done();
    check("busy_start_total", done_cyc, 55, 55);
    check("busy_start_stress", stress_cnt, 0, 0);
    check("busy_start_valids", valid_cnt, 3, 3);
    run_active = 0;

    // CMD_START together with CMD_ABORT in IDLE stays idle.
    @(posedge CLK); #1;
    bus.CMD_START = 1'b1; bus.CMD_ABORT = 1'b1;
    @(posedge CLK); #1;
    bus.CMD_START = 1'b0; bus.CMD_ABORT = 1'b0;
    @(negedge CLK);
    check("start_abort_busy", bus.BUSY, 0, 0);
    check("start_abort_ctl", {bus.EN_POWER_ROSC, bus.START, bus.SEL_INV99}, 0, 0);

    // Abort during MEAS of index 1.
    push_exp(1, 2, 3);
    start_run(1, 0, 0, 0, 20, 4);
    wait_cyc(39);
    bus.CMD_ABORT = 1'b1;
    @(posedge CLK); #1 bus.CMD_ABORT = 1'b0;
    @(negedge CLK);
    check("abort_ctl", {bus.SEL_INV99, bus.SEL_INV101, bus.SEL_INV97, bus.START,
                        bus.AC_STRESS_CLK, bus.EN_POWER_ROSC, bus.EN_ROSC}, 0, 0);
    check("abort_busy", bus.BUSY, 0, 0);
    repeat (100) @(negedge CLK);
    check("abort_valids", valid_cnt, 1, 1);
    check("abort_no_done", done_seen, 0, 0);
    check("abort_count_id", bus.COUNT_ID, 0, 0);
    check("abort_count_kept", bus.COUNT, 2, 3);
    check("abort_sb_empty", sb.size(), 0, 0);
    run_active = 0;

    // Saturation on the narrow-counter instance.
    @(posedge CLK); #1;
    bus2.MEAS_ONLY = 1; bus2.GATE_CYCLES = 100; bus2.CMD_START = 1'b1;
    @(posedge CLK); #1 bus2.CMD_START = 1'b0;
    nv = 0;
    n  = 0;
    while (!bus2.DONE && n < 2000) begin
      @(negedge CLK);
      n++;
      if (bus2.COUNT_VALID) begin
        nv++;
        check("sat_count", bus2.COUNT, 15, 15);
        check("sat_flag", bus2.COUNT_SAT, 1, 1);
      end
    end
    check("sat_done", bus2.DONE, 1, 1);
    check("sat_valids", nv, 3, 3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/odometer_seq_stacked.md
# odometer_seq_stacked

Synchronous sequencer for the stacked reference ring-oscillator odometer block. It runs a stress phase (AC or DC) on all three oscillators (INV99, INV101, INV97), then measures each one in turn. For each oscillator it enables that oscillator alone, lets it settle, and counts its synchronized `OUT` edges over a fixed gate window. It sits between the chip configuration/scan registers and the oscillator block's control pins, and returns one count per oscillator.

## Interface
Parameters:
- `CNT_W`, 16: edge-count width.
- `STRESS_W`, 24: stress-length field width.
- `GATE_W`, 12: gate-window field width.
- `SETTLE_CYCLES`, 8: settle length per oscillator, in clocks; must be ≥ 3.
- `AC_DIV_W`, 4: AC stress-clock divider field width.

Ports:
- `CLK` in 1: single clock.
- `RST` in 1: synchronous, active-high reset.
- `CMD_START` in 1: one-cycle pulse; starts a run when idle.
- `CMD_ABORT` in 1: level; forces return to idle.
- `MEAS_ONLY` in 1: skip the stress phase.
- `AC_MODE` in 1: 1 = AC stress, 0 = DC stress.
- `AC_DIV` in `AC_DIV_W`: AC stress-clock half-period in clocks, minus 1.
- `STRESS_CYCLES` in `STRESS_W`: stress length in clocks; 0 skips stress.
- `GATE_CYCLES` in `GATE_W`: gate window in clocks; 0 is treated as 1.
- `ROSC_OUT` in 1: `OUT` of the oscillator block; asynchronous.
- `SEL_INV99`, `SEL_INV101`, `SEL_INV97` out 1 each: oscillator selects.
- `START`, `AC_DC`, `AC_STRESS_CLK` out 1 each: stress controls.
- `EN_POWER_ROSC`, `EN_ROSC`, `MEAS_STRESS` out 1 each: power and ring enables.
- `COUNT` out `CNT_W`: last completed count.
- `COUNT_ID` out 2: source of `COUNT`; 0 = INV99, 1 = INV101, 2 = INV97.
- `COUNT_VALID` out 1: one-cycle pulse when `COUNT` is new.
- `COUNT_SAT` out 1: counter saturated in that window; qualified by `COUNT_VALID`.
- `BUSY` out 1: high in every state except IDLE.
- `DONE` out 1: one-cycle pulse at the end of a run.

## Operation
- States: IDLE, STRESS, SETTLE, MEAS, FINISH.
- All outputs are registered.
- Reset and IDLE output values:
  - All selects, `START`, `AC_DC`, `AC_STRESS_CLK`, `EN_POWER_ROSC`, `EN_ROSC` and `MEAS_STRESS` are 0, which leaves the oscillators unpowered.
  - `COUNT` = 0, `COUNT_ID` = 0, `COUNT_SAT` = 0, `COUNT_VALID` = 0, `BUSY` = 0, `DONE` = 0.
- IDLE:
  - On `CMD_START` with `CMD_ABORT` = 0, latch `MEAS_ONLY`, `AC_MODE`, `AC_DIV`, `STRESS_CYCLES` and `GATE_CYCLES`.
  - Go to STRESS, or straight to SETTLE with index 0 if `MEAS_ONLY` = 1 or `STRESS_CYCLES` = 0.
  - `CMD_START` while `BUSY` is ignored.
- STRESS:
  - Drive `EN_POWER_ROSC` = 1, `START` = 1, `AC_DC` = `AC_MODE`, `EN_ROSC` = 0, `MEAS_STRESS` = 0, all selects 0.
  - AC mode: `AC_STRESS_CLK` toggles every `AC_DIV`+1 clocks, starting at 0.
  - DC mode: `AC_STRESS_CLK` is held at 0.
  - After exactly `STRESS_CYCLES` clocks, go to SETTLE with index 0.
- SETTLE:
  - Drive `EN_POWER_ROSC` = 1, `EN_ROSC` = 1, `START` = 0, `AC_STRESS_CLK` = 0.
  - Drive the select for the current index one-hot; the other two selects are 0.
  - Last `SETTLE_CYCLES` clocks, then go to MEAS. This also flushes the synchronizer.
- MEAS:
  - Outputs are the same as in SETTLE.
  - Run a gate counter of max(`GATE_CYCLES`, 1) clocks.
  - The edge counter clears on MEAS entry.
  - It increments in each MEAS cycle where the 2-flop-synchronized `ROSC_OUT` (s2) = 1 and its delayed copy s3 = 0.
  - It saturates at 2^`CNT_W`−1 and sets an internal sat flag.
- MEAS exit:
  - In the cycle after the last gate cycle, pulse `COUNT_VALID` and load `COUNT`, `COUNT_ID` and `COUNT_SAT`.
  - Index < 2: increment the index and return to SETTLE.
  - Index = 2: go to FINISH.
- FINISH: hold one cycle with all rosc controls 0, pulse `DONE`, then go to IDLE.
- `CMD_ABORT` = 1 in any non-IDLE state:
  - Next state is IDLE and all rosc controls are 0 on the next clock.
  - No `COUNT_VALID` or `DONE` is issued.
  - `COUNT`, `COUNT_ID` and `COUNT_SAT` keep their last values.
- `RST` mid-run has the same effect as an abort, and additionally clears `COUNT`, `COUNT_ID` and `COUNT_SAT`.
- `MEAS_STRESS` is 0 in every state.

## Timing
- Start latency: with `CMD_START` sampled in cycle t, STRESS outputs appear at t+1.
- STRESS covers t+1 .. t+`STRESS_CYCLES`.
- Each oscillator slot lasts `SETTLE_CYCLES` + G clocks, where G = max(`GATE_CYCLES`, 1).
- `COUNT_VALID` for a slot coincides with the first cycle of the next slot (SETTLE or FINISH).
- Total run, from t+1 to the `DONE` cycle inclusive: S + 3·(`SETTLE_CYCLES` + G) + 1, where S = 0 if stress is skipped, else `STRESS_CYCLES`.
- `ROSC_OUT` to counter latency is 3 clocks (s1, s2, s3). Edges that arrive in the last 2 gate cycles may be counted in the next window only if it belongs to the same slot, which never happens; they are dropped.
- `AC_STRESS_CLK` edges align to `CLK`; its first toggle is at t+1+`AC_DIV`+1.

## Test plan
- Reset: assert `RST` for 2 cycles → all outputs 0; `BUSY` = 0.
- DC run:
  - Setup: `STRESS_CYCLES` = 20, `GATE_CYCLES` = 100, `AC_MODE` = 0; `ROSC_OUT` toggles every 4 clocks (period 8).
  - Stress controls: `START` = 1 and `EN_POWER_ROSC` = 1 for exactly 20 cycles; `AC_STRESS_CLK` stays 0.
  - Counts: three `COUNT_VALID` pulses with `COUNT_ID` 0, 1, 2 and `COUNT` = 12 or 13 each.
  - End: `DONE` at cycle 20 + 3·108 + 1 = 345 after start.
- AC stress: `AC_MODE` = 1, `AC_DIV` = 2, `STRESS_CYCLES` = 30 → `AC_STRESS_CLK` has period 6, 5 full periods, and `AC_DC` = 1 throughout stress.
- `MEAS_ONLY` = 1 → no STRESS cycles; the SETTLE select of index 0 is asserted at t+1.
- Saturation: `CNT_W` = 4, `ROSC_OUT` period 4, `GATE_CYCLES` = 100 → `COUNT` = 15 and `COUNT_SAT` = 1.
- Boundary commands:
  - Abort during MEAS of index 1 → controls 0 next cycle, no further `COUNT_VALID`, no `DONE`; `COUNT_ID` stays 0.
  - `CMD_START` during `BUSY` is ignored.
  - `CMD_START` together with `CMD_ABORT` in IDLE stays idle.
